aap_fetch_sequencer: RTL and testbench
======================================

Name: aap_fetch_sequencer

Overview:
Sits between the instruction fetch unit and the 16/32-bit instruction decoder.
- Accepts 16-bit halfwords from fetch over a valid/ready handshake.
- Classifies each instruction by bit 15 of its first halfword and assembles 32-bit instructions from two consecutive halfwords.
- Presents one whole instruction at a time to the decoder, tagged with its program counter, under a second valid/ready handshake.
- Handles pipeline flushes (branch redirect) by discarding partial and pending instructions.

Parameters:
PC_WIDTH, 24, width of the halfword-addressed program counter
RESET_PC, 0, PC value loaded on reset
CNT_WIDTH, 16, width of the issued-instruction counter

Ports:
clock  input  1  single system clock, rising edge
reset  input  1  asynchronous, active-low reset
fetch_valid  input  1  fetch_word is valid this cycle
fetch_word  input  16  halfword from fetch
fetch_ready  output  1  sequencer accepts fetch_word this cycle
dec_valid  output  1  dec_instr holds a complete instruction
dec_instr  output  32  instruction; 16-bit form zero-extended into [15:0]
dec_long  output  1  1 = 32-bit instruction
dec_pc  output  PC_WIDTH  halfword address of the instruction's first halfword
dec_ready  input  1  decoder consumes dec_instr this cycle
flush_valid  input  1  redirect request
flush_pc  input  PC_WIDTH  new fetch PC
issued_count  output  CNT_WIDTH  number of instructions handed to the decoder

Behaviour:
- Clock and reset: one clock (clock); reset is asynchronous and active-low (reset).
- Reset values: state=S_FIRST, dec_valid=0, dec_instr=0, dec_long=0, dec_pc=RESET_PC, internal pc=RESET_PC, low-half register=0, issued_count=0.
- Handshakes:
  - Fetch transfer = fetch_valid & fetch_ready.
  - Decoder transfer = dec_valid & dec_ready.
- fetch_ready = !flush_valid & (!dec_valid | dec_ready). Combinational; it never depends on fetch_word.
- States:
  - S_FIRST: awaiting the first halfword of an instruction.
  - S_SECOND: low half of a 32-bit instruction is held; awaiting the high half.
- S_FIRST, fetch transfer with fetch_word[15]=0:
  - dec_instr={16'h0, word}, dec_long=0, dec_pc=pc, dec_valid=1 next cycle.
  - pc+=1; stay in S_FIRST. Latency is 1 cycle.
- S_FIRST, fetch transfer with fetch_word[15]=1:
  - Store word in the low-half register; start_pc=pc; pc+=1; go to S_SECOND.
  - dec_valid is unaffected apart from normal consumption.
- S_SECOND, fetch transfer:
  - dec_instr={word, low_half}, dec_long=1, dec_pc=start_pc, dec_valid=1 next cycle.
  - pc+=1; go to S_FIRST. The bit 15 value of the second halfword is not checked.
- Output register:
  - Holds its value while dec_valid & !dec_ready.
  - Clears dec_valid on a decoder transfer with no new load.
  - A decoder transfer and a new load in the same cycle is legal; the new instruction replaces the old with no bubble.
- issued_count: +1 on every decoder transfer; wraps modulo 2^CNT_WIDTH.
- pc wraps modulo 2^PC_WIDTH. A 32-bit instruction may straddle the wrap.
- Flush (highest priority, synchronous):
  - Next cycle: state=S_FIRST, dec_valid=0, pc=flush_pc.
  - Discards any held low half and any unconsumed output.
  - fetch_ready=0 during the flush cycle, so no word is accepted.
  - A decoder transfer in the flush cycle still counts in issued_count.
- Reset asserted mid-operation: all registers return to reset values immediately, regardless of clock.
- Idle: fetch_valid=0 holds state; there is no timeout.

Decomposition:
- Shared package aap_pipe_pkg:
  - state encoding (S_FIRST=1'b0, S_SECOND=1'b1)
  - LONG_BIT=15, HALF_WIDTH=16, INSTR_WIDTH=32
  - default PC_WIDTH
- No sub-module needed: a single module with a state register, low-half register, output register and counter.
- The output register with its valid/ready hold logic may be factored as pipe_stage_reg if the decoder-to-execute stage needs the same logic.

Test Plan:
- Reset, then release with no stimulus -> dec_valid=0, fetch_ready=1, issued_count=0, and dec_pc=0 when RESET_PC=0.
- Send fetch_word=16'h020A with dec_ready=1 -> next cycle dec_valid=1, dec_instr=32'h0000020A, dec_long=0, dec_pc=0; issued_count=1 after consumption.
- Send 16'h8001 then 16'h8002 starting at pc=1 -> one output dec_instr=32'h80028001, dec_long=1, dec_pc=1; no dec_valid after the first halfword; internal pc=3.
- Hold dec_ready=0 with an instruction pending, then drive 16'h0003 -> fetch_ready=0 and dec_instr stable for 5 cycles. Raise dec_ready -> same-cycle accept; next cycle dec_instr=32'h00000003 with no bubble.
- Accept 16'h8005 (S_SECOND), then flush_valid=1 with flush_pc=24'h000100, then send 16'h0001 -> low half discarded, fetch_ready=0 in the flush cycle, output dec_instr=32'h00000001 with dec_pc=24'h000100.
- Assert reset mid-way through a 32-bit pair and while dec_valid=1 -> dec_valid drops asynchronously. After release, 16'h0007 gives dec_pc=RESET_PC and issued_count=1.

Source files
------------

// File: rtl/aap_pipe_pkg.sv
// Shared types and constants for the 16/32-bit fetch-to-decode pipe.
package aap_pipe_pkg;

    typedef enum logic {
        S_FIRST  = 1'b0,
        S_SECOND = 1'b1
    } seq_state_t;

    localparam int LONG_BIT     = 15;
    localparam int HALF_WIDTH   = 16;
    localparam int INSTR_WIDTH  = 32;
    localparam int DEF_PC_WIDTH = 24;

    typedef struct packed {
        logic [INSTR_WIDTH-1:0] instr;
        logic                   is_long;
    } dec_dat_t;

endpackage

// File: rtl/aap_fetch_sequencer.sv
// Assembles 16-bit fetch halfwords into whole 16/32-bit instructions for the decoder.
// Latency: 1 cycle from the final halfword accepted to dec_valid.
// Backpressure: fetch_ready drops while a flush is requested or the output is held by dec_ready.
module aap_fetch_sequencer
    import aap_pipe_pkg::*;
#(
    parameter int                  PC_WIDTH  = DEF_PC_WIDTH,
    parameter logic [PC_WIDTH-1:0] RESET_PC  = '0,
    parameter int                  CNT_WIDTH = 16
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   fetch_valid,
    input  logic [HALF_WIDTH-1:0]  fetch_word,
    output logic                   fetch_ready,
    output logic                   dec_valid,
    output logic [INSTR_WIDTH-1:0] dec_instr,
    output logic                   dec_long,
    output logic [PC_WIDTH-1:0]    dec_pc,
    input  logic                   dec_ready,
    input  logic                   flush_valid,
    input  logic [PC_WIDTH-1:0]    flush_pc,
    output logic [CNT_WIDTH-1:0]   issued_count
);

    seq_state_t            r_state;
    seq_state_t            w_state_nxt;
    logic [PC_WIDTH-1:0]   r_pc;
    logic [PC_WIDTH-1:0]   r_start_pc;
    logic [HALF_WIDTH-1:0] r_low_half;
    logic                  r_dec_vld;
    dec_dat_t              r_dec_dat;
    logic [PC_WIDTH-1:0]   r_dec_pc;
    logic [CNT_WIDTH-1:0]  r_issued;

    logic                  w_fetch_xfer;
    logic                  w_dec_xfer;
    logic                  w_load;
    dec_dat_t              w_load_dat;
    logic [PC_WIDTH-1:0]   w_load_pc;

    assign fetch_ready  = !flush_valid && (!r_dec_vld || dec_ready);
    assign w_fetch_xfer = fetch_valid && fetch_ready;
    assign w_dec_xfer   = r_dec_vld && dec_ready;

    always_comb begin
        w_state_nxt = r_state;
        w_load      = 1'b0;
        w_load_dat  = r_dec_dat;
        w_load_pc   = r_dec_pc;
        if (w_fetch_xfer) begin
            if (r_state == S_FIRST) begin
                if (!fetch_word[LONG_BIT]) begin
                    w_load     = 1'b1;
                    w_load_dat = '{instr:   {{(INSTR_WIDTH-HALF_WIDTH){1'b0}}, fetch_word},
                                   is_long: 1'b0};
                    w_load_pc  = r_pc;
                end else begin
                    w_state_nxt = S_SECOND;
                end
            end else begin
                // The high half is taken as-is; its bit 15 carries no meaning.
                w_load      = 1'b1;
                w_load_dat  = '{instr: {fetch_word, r_low_half}, is_long: 1'b1};
                w_load_pc   = r_start_pc;
                w_state_nxt = S_FIRST;
            end
        end
        if (flush_valid) begin
            w_state_nxt = S_FIRST;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state    <= S_FIRST;
            r_pc       <= RESET_PC;
            r_start_pc <= RESET_PC;
            r_low_half <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (flush_valid) begin
                r_pc <= flush_pc;
            end else if (w_fetch_xfer) begin
                r_pc <= r_pc + 1'b1;
                if (r_state == S_FIRST && fetch_word[LONG_BIT]) begin
                    r_low_half <= fetch_word;
                    r_start_pc <= r_pc;
                end
            end
        end
    end

    // A consume and a new load may coincide; the load wins so there is no bubble.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_dec_vld <= 1'b0;
            r_dec_dat <= '0;
            r_dec_pc  <= RESET_PC;
        end else if (flush_valid) begin
            r_dec_vld <= 1'b0;
        end else if (w_load) begin
            r_dec_vld <= 1'b1;
            r_dec_dat <= w_load_dat;
            r_dec_pc  <= w_load_pc;
        end else if (w_dec_xfer) begin
            r_dec_vld <= 1'b0;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_issued <= '0;
        end else if (w_dec_xfer) begin
            r_issued <= r_issued + 1'b1;
        end
    end

    assign dec_valid    = r_dec_vld;
    assign dec_instr    = r_dec_dat.instr;
    assign dec_long     = r_dec_dat.is_long;
    assign dec_pc       = r_dec_pc;
    assign issued_count = r_issued;

endmodule

// File: tb/tb_aap_fetch_sequencer.sv
// Directed and randomized checks of aap_fetch_sequencer against an instruction-level model.
module tb_aap_fetch_sequencer;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        fv = 1'b0;
    logic [15:0] fw = '0;
    logic        dr = 1'b0;
    logic        fl = 1'b0;
    logic [23:0] fpc = '0;

    logic        fetch_ready;
    logic        dec_valid;
    logic [31:0] dec_instr;
    logic        dec_long;
    logic [23:0] dec_pc;
    logic [15:0] issued_count;

    int n_chk = 0;
    int n_fail = 0;

    aap_fetch_sequencer dut (
        .clock        (clk),
        .reset        (rst_n),
        .fetch_valid  (fv),
        .fetch_word   (fw),
        .fetch_ready  (fetch_ready),
        .dec_valid    (dec_valid),
        .dec_instr    (dec_instr),
        .dec_long     (dec_long),
        .dec_pc       (dec_pc),
        .dec_ready    (dr),
        .flush_valid  (fl),
        .flush_pc     (fpc),
        .issued_count (issued_count)
    );

    always #5 clk = ~clk;

    // Model: halfwords of the instruction being gathered, plus the presented instruction.
    logic [15:0] m_part[$];
    logic [23:0] m_part_pc;
    logic [23:0] m_pc = '0;
    logic        m_valid = 1'b0;
    logic [31:0] m_instr = '0;
    logic        m_long = 1'b0;
    logic [23:0] m_dpc = '0;
    logic [15:0] m_cnt = '0;

    initial begin
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                m_part.delete();
                m_pc = '0; m_valid = 1'b0; m_instr = '0; m_long = 1'b0;
                m_dpc = '0; m_cnt = '0;
            end else begin
                automatic bit rdy  = !fl && (!m_valid || dr);
                automatic bit take = fv && rdy;
                automatic bit cons = m_valid && dr;
                automatic bit done = 1'b0;
                if (cons) m_cnt = m_cnt + 16'd1;
                if (fl) begin
                    m_part.delete();
                    m_valid = 1'b0;
                    m_pc = fpc;
                end else begin
                    if (take) begin
                        if (m_part.size() == 0) m_part_pc = m_pc;
                        m_part.push_back(fw);
                        if (m_part.size() == 1 && !fw[15]) begin
                            m_instr = {16'h0, fw}; m_long = 1'b0; m_dpc = m_part_pc;
                            m_part.delete(); done = 1'b1;
                        end else if (m_part.size() == 2) begin
                            m_instr = {m_part[1], m_part[0]}; m_long = 1'b1; m_dpc = m_part_pc;
                            m_part.delete(); done = 1'b1;
                        end
                        m_pc = m_pc + 24'd1;
                    end
                    if (done) m_valid = 1'b1;
                    else if (cons) m_valid = 1'b0;
                end
            end
        end
    end

    task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    always @(negedge clk) begin
        cmp("fetch_ready", {31'h0, fetch_ready}, {31'h0, (!fl && (!m_valid || dr))});
        cmp("dec_valid", {31'h0, dec_valid}, {31'h0, m_valid});
        cmp("dec_instr", dec_instr, m_instr);
        cmp("dec_long", {31'h0, dec_long}, {31'h0, m_long});
        cmp("dec_pc", {8'h0, dec_pc}, {8'h0, m_dpc});
        cmp("issued_count", {16'h0, issued_count}, {16'h0, m_cnt});
    end

    task automatic setin(input bit v, input logic [15:0] w, input bit r, input bit f,
                         input logic [23:0] p);
        fv = v; fw = w; dr = r; fl = f; fpc = p;
    endtask

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic cyc(input bit v, input logic [15:0] w, input bit r, input bit f,
                       input logic [23:0] p);
        setin(v, w, r, f, p);
        step();
    endtask

    initial begin
        #1 rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;
        step();
        cmp("lit_rst_valid", {31'h0, dec_valid}, 32'h0);
        cmp("lit_rst_fready", {31'h0, fetch_ready}, 32'h1);
        cmp("lit_rst_count", {16'h0, issued_count}, 32'h0);
        cmp("lit_rst_pc", {8'h0, dec_pc}, 32'h0);

        cyc(1, 16'h020A, 1, 0, 0);
        cmp("lit_short_valid", {31'h0, dec_valid}, 32'h1);
        cmp("lit_short_instr", dec_instr, 32'h0000020A);
        cmp("lit_short_long", {31'h0, dec_long}, 32'h0);
        cmp("lit_short_pc", {8'h0, dec_pc}, 32'h0);
        cyc(0, 16'h0, 1, 0, 0);
        cmp("lit_short_count", {16'h0, issued_count}, 32'h1);

        cyc(1, 16'h8001, 1, 0, 0);
        cmp("lit_half_novalid", {31'h0, dec_valid}, 32'h0);
        cyc(1, 16'h8002, 1, 0, 0);
        cmp("lit_long_instr", dec_instr, 32'h80028001);
        cmp("lit_long_long", {31'h0, dec_long}, 32'h1);
        cmp("lit_long_pc", {8'h0, dec_pc}, 32'h1);

        for (int i = 0; i < 5; i++) begin
            cyc(1, 16'h0003, 0, 0, 0);
            cmp("lit_hold_fready", {31'h0, fetch_ready}, 32'h0);
            cmp("lit_hold_instr", dec_instr, 32'h80028001);
        end
        setin(1, 16'h0003, 1, 0, 0);
        #1 cmp("lit_release_fready", {31'h0, fetch_ready}, 32'h1);
        step();
        cmp("lit_nobubble_valid", {31'h0, dec_valid}, 32'h1);
        cmp("lit_nobubble_instr", dec_instr, 32'h00000003);
        cmp("lit_nobubble_pc", {8'h0, dec_pc}, 32'h3);
        cmp("lit_nobubble_count", {16'h0, issued_count}, 32'h2);
        cyc(0, 16'h0, 1, 0, 0);

        cyc(1, 16'h8005, 1, 0, 0);
        setin(1, 16'h1234, 1, 1, 24'h000100);
        #1 cmp("lit_flush_fready", {31'h0, fetch_ready}, 32'h0);
        step();
        cmp("lit_flush_valid", {31'h0, dec_valid}, 32'h0);
        cyc(1, 16'h0001, 1, 0, 0);
        cmp("lit_postflush_instr", dec_instr, 32'h00000001);
        cmp("lit_postflush_long", {31'h0, dec_long}, 32'h0);
        cmp("lit_postflush_pc", {8'h0, dec_pc}, 32'h100);
        cyc(0, 16'h0, 0, 0, 0);

        #2 rst_n = 1'b0;
        #1 cmp("lit_async_valid", {31'h0, dec_valid}, 32'h0);
        cmp("lit_async_count", {16'h0, issued_count}, 32'h0);
        step();
        rst_n = 1'b1;
        cyc(1, 16'h8009, 1, 0, 0);
        #2 rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        cyc(1, 16'h0007, 1, 0, 0);
        cmp("lit_rst2_instr", dec_instr, 32'h00000007);
        cmp("lit_rst2_pc", {8'h0, dec_pc}, 32'h0);
        cyc(0, 16'h0, 1, 0, 0);
        cmp("lit_rst2_count", {16'h0, issued_count}, 32'h1);

        for (int i = 0; i < 4000; i++) begin
            automatic logic [15:0] w = 16'($urandom);
            automatic logic [23:0] p = ($urandom_range(0, 3) == 0) ? 24'hFFFFFF : 24'($urandom);
            if ($urandom_range(0, 799) == 0) begin
                rst_n = 1'b0;
                step();
                rst_n = 1'b1;
            end
            cyc($urandom_range(0, 9) < 7, w, $urandom_range(0, 9) < 6,
                $urandom_range(0, 19) == 0, p);
        end
        cyc(0, 16'h0, 0, 0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
